exp_batch_scheduler: RTL and testbench

Batch sequencer that sits directly upstream of the exponential-series datapath/control unit and consumes its result. On `start` it walks `count` operands from a sample RAM, launches one series evaluation per operand using the unit's `s`/`s_done` handshake, then accumulates the returned results and tracks the largest one. It reports sum, arg-max index and value with a one-cycle `done` pulse. A watchdog aborts the batch if the series unit stalls.

---
 rtl/exp_pkg.sv | 29 ++
 rtl/argmax_tracker.sv | 54 +++++
 rtl/exp_batch_scheduler.sv | 141 ++++++++++++++
 tb/tb_exp_batch_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types and helpers for the exponential-series batch path.
package exp_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_LAUNCH,
    S_WAIT,
    S_ACCUM,
    S_FINISH
  } sched_state_t;

  // Unsigned add clamped to 2**w-1. Operands are zero-extended to 32 bits,
  // so this is good for any width up to 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum over a stream of values; the earliest index wins ties.
module argmax_tracker
  import exp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] val,
  output logic [ADDR_W-1:0] best_idx,
  output logic [DATA_W-1:0] best_val
);

  logic              first_q, first_d;
  logic [ADDR_W-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;

  // The first value after clear always loads; later only a strictly larger one does.
  always_comb begin
    first_d    = first_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clear) begin
      first_d    = 1'b1;
      best_idx_d = '0;
      best_val_d = '0;
    end else if (valid && (first_q || (val > best_val_q))) begin
      first_d    = 1'b0;
      best_idx_d = idx;
      best_val_d = val;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b1;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      first_q    <= first_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign best_idx = best_idx_q;
  assign best_val = best_val_q;

endmodule

// File: rtl/exp_batch_scheduler.sv
// Walks a sample RAM, runs one series evaluation per sample, and reduces the
// results to a saturating sum and an arg-max. A watchdog aborts stalled runs.
module exp_batch_scheduler
  import exp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              exp_s,
  output logic [DATA_W-1:0] exp_x,
  input  logic              exp_done,
  input  logic [DATA_W-1:0] exp_result,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ACC_W-1:0]  sum,
  output logic [ADDR_W-1:0] best_idx,
  output logic [DATA_W-1:0] best_val
);

  // Watchdog only needs to reach TIMEOUT-1: the last WAIT cycle aborts.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  sched_state_t      state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] exp_x_q, exp_x_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              trk_clear, trk_valid;
  logic              last;

  assign last = ({1'b0, idx_q} == (count_q - (ADDR_W+1)'(1)));

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    error_d   = error_q;
    exp_x_d   = exp_x_q;
    wd_d      = wd_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        count_d   = count;
        idx_d     = '0;
        sum_d     = '0;
        error_d   = 1'b0;
        trk_clear = 1'b1;
        state_d   = (count == '0) ? S_FINISH : S_FETCH;
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        exp_x_d = rd_data;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      // A done arriving on the final watchdog cycle still counts as success.
      S_WAIT: begin
        if (exp_done) begin
          state_d = S_ACCUM;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ACCUM: begin
        sum_d     = ACC_W'(sat_add(32'(sum_q), 32'(exp_result), ACC_W));
        trk_valid = 1'b1;
        if (last) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      error_q <= 1'b0;
      exp_x_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      error_q <= error_d;
      exp_x_q <= exp_x_d;
      wd_q    <= wd_d;
    end
  end

  argmax_tracker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clear    (trk_clear),
    .valid    (trk_valid),
    .idx      (idx_q),
    .val      (exp_result),
    .best_idx (best_idx),
    .best_val (best_val)
  );

  assign rd_en   = (state_q == S_FETCH);
  assign rd_addr = idx_q;
  assign exp_s   = (state_q == S_LAUNCH);
  assign exp_x   = exp_x_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);
  assign error   = error_q;
  assign sum     = sum_q;

endmodule

// File: tb/tb_exp_batch_scheduler.sv
// Bench for exp_batch_scheduler: RAM and series-unit models, directed and
// random batches checked against a plain arithmetic reference.
module tb_exp_batch_scheduler;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 16;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          exp_s;
  logic [DW-1:0] exp_x;
  logic          exp_done;
  logic [DW-1:0] exp_result;
  logic          busy, done, error;
  logic [CW-1:0] sum;
  logic [AW-1:0] best_idx;
  logic [DW-1:0] best_val;

  exp_batch_scheduler #(.DATA_W(DW), .ACC_W(CW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .exp_s(exp_s), .exp_x(exp_x), .exp_done(exp_done), .exp_result(exp_result),
    .busy(busy), .done(done), .error(error),
    .sum(sum), .best_idx(best_idx), .best_val(best_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs read by the models.
  logic [DW-1:0] ram [16];
  bit            stall = 1'b0;
  bit            mode  = 1'b0;   // 0: result = x+1, 1: result = x
  int            fixed_lat = 0;  // 0 selects a random latency 1..8

  // Sample RAM: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  // Series unit: done after lat WAIT cycles, result the cycle after done.
  int            lat_arr [1024];
  int            launch_n = 0;
  int            cnt = 0;
  bit            pending = 1'b0;
  int            mdl_l;
  logic [DW-1:0] x_l = '0;
  always @(posedge clk) begin
    if (rst) begin
      exp_done   <= 1'b0;
      exp_result <= '0;
      pending    <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (exp_done) exp_result <= mode ? x_l : x_l + 16'd1;
      if (exp_s) begin
        mdl_l = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
        lat_arr[launch_n % 1024] <= mdl_l;
        launch_n <= launch_n + 1;
        x_l      <= exp_x;
        if (!stall) begin
          if (mdl_l == 1) exp_done <= 1'b1;
          else begin pending <= 1'b1; cnt <= mdl_l - 1; end
        end
      end else if (pending) begin
        if (cnt == 1) begin exp_done <= 1'b1; pending <= 1'b0; end
        else cnt <= cnt - 1;
      end
    end
  end

  // Pulse counters sampled mid-cycle.
  int rd_cnt = 0, s_cnt = 0, done_cnt = 0, wide_cnt = 0;
  bit s_prev = 1'b0;
  always @(negedge clk) begin
    rd_cnt   += int'(rd_en);
    s_cnt    += int'(exp_s);
    done_cnt += int'(done);
    if (exp_s && s_prev) wide_cnt++;
    s_prev = exp_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present start across edge 0; returns #1 into cycle 1.
  task automatic launch(input int n);
    @(posedge clk); #1;
    count = n[AW:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One complete batch over ram[0..n-1]; xa/xb are cycles carrying extra starts.
  task automatic do_batch(input int n, input int xa, input int xb);
    int r0, s0, d0, w0, l0, cyc, exp_cyc, bi;
    longint acc;
    logic [DW-1:0] r, bv;
    acc = 0; bi = 0; bv = '0;
    for (int i = 0; i < n; i++) begin
      r = mode ? ram[i] : ram[i] + 16'd1;
      acc += longint'(r);
      if (i == 0 || r > bv) begin bv = r; bi = i; end
    end
    if (acc > 65535) acc = 65535;
    r0 = rd_cnt; s0 = s_cnt; d0 = done_cnt; w0 = wide_cnt; l0 = launch_n;
    launch(n);
    check("error_cleared_on_start", {31'd0, error}, 0);
    cyc = 1;
    while (!done && cyc < 3000) begin
      start = (cyc == xa) || (cyc == xb);
      if (start) count = 5'd1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    exp_cyc = 1;
    for (int i = 0; i < n; i++) exp_cyc += 4 + lat_arr[(l0 + i) % 1024];
    check("done_seen", {31'd0, done}, 1);
    check("done_cycle", cyc, exp_cyc);
    check("sum", {16'd0, sum}, acc[31:0]);
    check("best_idx", {28'd0, best_idx}, bi);
    check("best_val", {16'd0, best_val}, {16'd0, bv});
    check("error_clear", {31'd0, error}, 0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 0);
    check("idle_after", {31'd0, busy}, 0);
    check("sum_held", {16'd0, sum}, acc[31:0]);
    check("rd_en_pulses", rd_cnt - r0, n);
    check("exp_s_pulses", s_cnt - s0, n);
    check("done_pulses", done_cnt - d0, 1);
    check("exp_s_width", wide_cnt - w0, 0);
  endtask

  initial begin
    int cyc, r0, s0, n;
    rst = 1'b1; start = 1'b0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_sum", {16'd0, sum}, 0);
    check("rst_best_idx", {28'd0, best_idx}, 0);
    check("rst_best_val", {16'd0, best_val}, 0);
    check("rst_rd_en", {31'd0, rd_en}, 0);
    check("rst_exp_s", {31'd0, exp_s}, 0);
    rst = 1'b0;

    // Basic three-sample batch: results 6,10,3.
    ram[0] = 16'd5; ram[1] = 16'd9; ram[2] = 16'd2;
    mode = 1'b0; fixed_lat = 6;
    do_batch(3, 0, 0);
    check("basic_sum_19", {16'd0, sum}, 19);
    check("basic_best_val_10", {16'd0, best_val}, 10);

    // Empty batch clears the previous outputs.
    do_batch(0, 0, 0);

    // Tie plus saturation.
    mode = 1'b1; ram[0] = 16'hFFF0; ram[1] = 16'hFFF0;
    do_batch(2, 0, 0);
    check("sat_sum", {16'd0, sum}, 32'hFFFF);
    check("tie_idx", {28'd0, best_idx}, 0);

    // Stall: WAIT enters in cycle 4, done is the 11th cycle counting that one.
    stall = 1'b1; fixed_lat = 0; mode = 1'b0;
    r0 = rd_cnt; s0 = s_cnt;
    launch(2);
    cyc = 1;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("stall_done_cycle", cyc, 4 + TO);
    check("stall_error", {31'd0, error}, 1);
    check("stall_sum", {16'd0, sum}, 0);
    check("stall_best_val", {16'd0, best_val}, 0);
    check("stall_launches", s_cnt - s0, 1);
    @(posedge clk); #1;
    check("stall_error_sticky", {31'd0, error}, 1);
    check("stall_rd_en", rd_cnt - r0, 1);
    stall = 1'b0;

    // Extra starts during WAIT (cycle 5) and ACCUM (cycle 10) are ignored.
    ram[0] = 16'd5; ram[1] = 16'd9; ram[2] = 16'd2;
    fixed_lat = 6;
    do_batch(3, 5, 10);

    // Reset during WAIT of sample 1 (cycles 14..19).
    launch(3);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_sum", {16'd0, sum}, 0);
    check("mid_rst_best_val", {16'd0, best_val}, 0);
    check("mid_rst_best_idx", {28'd0, best_idx}, 0);
    check("mid_rst_exp_x", {16'd0, exp_x}, 0);
    check("mid_rst_exp_s", {31'd0, exp_s}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ram[0] = 16'd40;
    do_batch(1, 0, 0);

    // Random batches: random sizes, data, latencies and result mapping.
    fixed_lat = 0;
    repeat (12) begin
      n    = int'($urandom_range(1, 16));
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++)
        ram[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                              : 16'($urandom_range(0, 4095));
      do_batch(n, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
